// File: rtl/central_registers.sv
// Central register file: five 16-bit registers (A, L, Q, Z, B) with clear/write/OR-in
// update rules, a wired-OR read bus and A overflow/underflow indicators.
module central_registers (
  input  logic        SIM_CLK,
  input  logic        SIM_RST,
  input  logic [15:0] WL,
  input  logic        WAG_n,
  input  logic        WLG_n,
  input  logic        WQG_n,
  input  logic        WZG_n,
  input  logic        WBG_n,
  input  logic        CAG,
  input  logic        CLG1G,
  input  logic        CQG,
  input  logic        CZG,
  input  logic        CBG,
  input  logic        RAG_n,
  input  logic        RLG_n,
  input  logic        RQG_n,
  input  logic        RZG_n,
  input  logic        RBLG_n,
  output logic [15:0] RL,
  output logic [15:0] A_Q,
  output logic [15:0] L_Q,
  output logic [15:0] Q_Q,
  output logic [15:0] Z_Q,
  output logic [15:0] B_Q,
  output logic        OVF_n,
  output logic        UNF_n
);

  localparam int unsigned W = 16;

  logic [W-1:0] a_q, l_q, q_q, z_q, b_q;
  logic [W-1:0] a_d, l_d, q_d, z_d, b_d;

  // Clear+write loads, clear alone zeroes, write alone ORs in, neither holds.
  function automatic logic [W-1:0] next_reg(input logic [W-1:0] cur,
                                            input logic [W-1:0] wl,
                                            input logic         clr,
                                            input logic         wr_n);
    logic [W-1:0] base;
    base = clr ? '0 : cur;
    return wr_n ? base : (base | wl);
  endfunction

  always_comb begin
    a_d = next_reg(a_q, WL, CAG,   WAG_n);
    l_d = next_reg(l_q, WL, CLG1G, WLG_n);
    q_d = next_reg(q_q, WL, CQG,   WQG_n);
    z_d = next_reg(z_q, WL, CZG,   WZG_n);
    b_d = next_reg(b_q, WL, CBG,   WBG_n);
  end

  always_ff @(posedge SIM_CLK) begin
    if (!SIM_RST) begin
      a_q <= '0;
      l_q <= '0;
      q_q <= '0;
      z_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= a_d;
      l_q <= l_d;
      q_q <= q_d;
      z_q <= z_d;
      b_q <= b_d;
    end
  end

  // Read bus reflects pre-edge contents, so read-during-write returns the old value.
  always_comb begin
    RL = '0;
    if (!RAG_n)  RL = RL | a_q;
    if (!RLG_n)  RL = RL | l_q;
    if (!RQG_n)  RL = RL | q_q;
    if (!RZG_n)  RL = RL | z_q;
    if (!RBLG_n) RL = RL | b_q;
  end

  // Bit 15 is the overflow sign, bit 14 the true sign; disagreement flags overflow.
  assign OVF_n = ~(~a_q[15] & a_q[14]);
  assign UNF_n = ~(a_q[15] & ~a_q[14]);

  assign A_Q = a_q;
  assign L_Q = l_q;
  assign Q_Q = q_q;
  assign Z_Q = z_q;
  assign B_Q = b_q;

endmodule
